// File: rtl/eeprom_arb_if.sv
// rtl/eeprom_arb_if.sv - requester and at24c02_ctl signal bundle for the EEPROM arbiter
interface eeprom_arb_if;
  logic        r0_req;
  logic        r1_req;
  logic [10:0] r0_addr;
  logic [10:0] r1_addr;
  logic [7:0]  r0_din;
  logic [7:0]  r1_din;
  logic        r0_wr_en;
  logic        r1_wr_en;
  logic        r0_last;
  logic        r1_last;
  logic        r0_ack;
  logic        r1_ack;
  logic        r0_err;
  logic        r1_err;
  logic [7:0]  r0_dout;
  logic [7:0]  r1_dout;
  logic [10:0] address;
  logic [7:0]  din;
  logic        wr_en;
  logic        last;
  logic        ready;
  logic        valid;
  logic [7:0]  dout;

  modport slave (
    input  r0_req, r1_req, r0_addr, r1_addr, r0_din, r1_din,
    input  r0_wr_en, r1_wr_en, r0_last, r1_last, valid, dout,
    output r0_ack, r1_ack, r0_err, r1_err, r0_dout, r1_dout,
    output address, din, wr_en, last, ready
  );

  modport master (
    output r0_req, r1_req, r0_addr, r1_addr, r0_din, r1_din,
    output r0_wr_en, r1_wr_en, r0_last, r1_last, valid, dout,
    input  r0_ack, r1_ack, r0_err, r1_err, r0_dout, r1_dout,
    input  address, din, wr_en, last, ready
  );
endinterface

// File: rtl/eeprom_arb.sv
// rtl/eeprom_arb.sv - two-requester burst arbiter in front of an at24c02_ctl instance
module eeprom_arb #(
  parameter int unsigned TIMEOUT = 65535
) (
  input logic        clk,
  input logic        rst,
  eeprom_arb_if.slave bus
);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE, HOLD} state_t;

  state_t        state_q, state_d;
  logic          g_q, g_d;
  logic          p_q, p_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    err_q, err_d;
  logic [7:0]    dout0_q, dout0_d;
  logic [7:0]    dout1_q, dout1_d;

  logic          issue;
  logic          sel_req;
  logic [10:0]   sel_addr;
  logic [7:0]    sel_din;
  logic          sel_wr;
  logic          sel_last;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;

  assign sel_req  = g_q ? bus.r1_req   : bus.r0_req;
  assign sel_addr = g_q ? bus.r1_addr  : bus.r0_addr;
  assign sel_din  = g_q ? bus.r1_din   : bus.r0_din;
  assign sel_wr   = g_q ? bus.r1_wr_en : bus.r0_wr_en;
  assign sel_last = g_q ? bus.r1_last  : bus.r0_last;

  // Saturating count; the abort fires on the cycle the count would reach TIMEOUT.
  assign cnt_inc     = (cnt_q == TMAX) ? cnt_q : cnt_q + CW'(1);
  assign timeout_hit = (cnt_inc == TMAX);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    p_d     = p_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    dout0_d = dout0_q;
    dout1_d = dout1_q;
    case (state_q)
      IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          g_d     = (bus.r0_req && bus.r1_req) ? p_q : bus.r1_req;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.valid) begin
          if (g_q) dout1_d = bus.dout;
          else     dout0_d = bus.dout;
          ack_d[g_q] = 1'b1;
          last_d     = sel_last;
          state_d    = DONE;
        end else if (timeout_hit) begin
          err_d[g_q] = 1'b1;
          p_d        = ~g_q;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: begin
        if (last_q) begin
          p_d     = ~g_q;
          state_d = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (sel_req) begin
          cnt_d   = '0;
          state_d = ISSUE;
        end else if (timeout_hit) begin
          err_d[g_q] = 1'b1;
          p_d        = ~g_q;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= 1'b0;
      p_q     <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      dout0_q <= 8'h00;
      dout1_q <= 8'h00;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      p_q     <= p_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dout0_q <= dout0_d;
      dout1_q <= dout1_d;
    end
  end

  // Controller fields are only non-zero while a beat is actually presented.
  assign issue       = (state_q == ISSUE);
  assign bus.ready   = issue;
  assign bus.address = issue ? sel_addr : 11'd0;
  assign bus.din     = issue ? sel_din  : 8'd0;
  assign bus.wr_en   = issue & sel_wr;
  assign bus.last    = issue & sel_last;

  assign bus.r0_ack  = ack_q[0];
  assign bus.r1_ack  = ack_q[1];
  assign bus.r0_err  = err_q[0];
  assign bus.r1_err  = err_q[1];
  assign bus.r0_dout = dout0_q;
  assign bus.r1_dout = dout1_q;
endmodule

// File: tb/tb_eeprom_arb.sv
// tb/tb_eeprom_arb.sv - scoreboard bench for eeprom_arb with an EEPROM controller model
module tb_eeprom_arb;
  localparam int unsigned TO = 8;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  din;
    logic        wr;
    logic        last;
    logic [7:0]  rdata;
    logic        err;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  eeprom_arb_if bus();

  eeprom_arb #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_cyc = -10;
  int owner = -1;
  int grant_log[$];
  beat_t exp_q0[$];
  beat_t exp_q1[$];
  logic [7:0] ref_mem [0:2047];
  logic [7:0] ee_mem [0:2047];
  logic mute;
  logic [10:0] cap_addr;
  logic [7:0]  cap_din;
  logic        cap_wr;
  logic        cap_last;
  logic [7:0]  prev_dout0, prev_dout1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input logic [10:0] a);
    return a[7:0] ^ {a[10:8], 5'h15};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_order(input string nm, input int n, input logic [7:0] bits);
    chk({nm, "_len"}, 32'(grant_log.size()), 32'(n));
    for (int i = 0; i < n && i < grant_log.size(); i++)
      chk(nm, 32'(grant_log[i]), 32'(bits[i]));
  endtask

  task automatic set_req(input int n, input logic r, input logic [10:0] a, input logic [7:0] d,
                         input logic w, input logic l);
    if (n == 0) begin
      bus.r0_req = r; bus.r0_addr = a; bus.r0_din = d; bus.r0_wr_en = w; bus.r0_last = l;
    end else begin
      bus.r1_req = r; bus.r1_addr = a; bus.r1_din = d; bus.r1_wr_en = w; bus.r1_last = l;
    end
  endtask

  // mode: 0 write, 1 read, 2 random; din_fix < 0 picks random write data
  task automatic do_burst(input int n, input int nb, input logic [10:0] a0, input int mode,
                          input int din_fix, input logic exp_err);
    beat_t e;
    logic got;
    @(negedge clk);
    #1;
    for (int i = 0; i < nb; i++) begin
      e.addr = a0 + 11'(i);
      e.wr   = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 0);
      e.din  = (din_fix < 0) ? 8'($urandom) : 8'(din_fix);
      e.last = (i == nb - 1);
      e.err  = exp_err;
      if (e.wr) begin
        ref_mem[e.addr] = e.din;
        e.rdata = e.din;
      end else begin
        e.rdata = ref_mem[e.addr];
      end
      if (n == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      set_req(n, 1'b1, e.addr, e.din, e.wr, e.last);
      got = 1'b0;
      for (int w = 0; w < 100 && !got; w++) begin
        @(negedge clk);
        got = (n == 0) ? (bus.r0_ack | bus.r0_err) : (bus.r1_ack | bus.r1_err);
      end
      chk("resp_wait", 32'(got), 32'd1);
      #1;
      if (!got || exp_err) break;
    end
    set_req(n, 1'b0, 11'd0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic mon_resp(input int n, input logic ack, input logic err,
                          input logic [7:0] dout, input logic [7:0] prev);
    beat_t e;
    logic empty;
    if (ack || err) begin
      empty = (n == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      if (empty) begin
        total++;
        bad++;
        $display("FAIL spurious_resp r%0d actual ack=%0b err=%0b required none", n, ack, err);
      end else begin
        if (n == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
        chk("resp_kind", 32'({ack, err}), 32'({~e.err, e.err}));
        if (ack) begin
          chk("ack_latency", 32'(cyc), 32'(valid_cyc + 1));
          chk("rdata", 32'(dout), 32'(e.rdata));
          chk("ctl_fields", 32'({cap_addr, cap_din, cap_wr, cap_last}),
              32'({e.addr, e.din, e.wr, e.last}));
        end
        if (owner < 0) grant_log.push_back(n);
        else chk("no_preempt", 32'(n), 32'(owner));
        owner = (err || e.last) ? -1 : n;
      end
    end else begin
      chk("dout_hold", 32'(dout), 32'(prev));
    end
  endtask

  // Scoreboard monitor
  initial begin
    prev_dout0 = 8'h00;
    prev_dout1 = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("single_resp", 32'($countones({bus.r0_ack, bus.r1_ack, bus.r0_err, bus.r1_err}) <= 1), 32'd1);
        mon_resp(0, bus.r0_ack, bus.r0_err, bus.r0_dout, prev_dout0);
        mon_resp(1, bus.r1_ack, bus.r1_err, bus.r1_dout, prev_dout1);
        if (!bus.ready)
          chk("idle_bus", 32'({bus.address, bus.din, bus.wr_en, bus.last}), 32'd0);
      end
      prev_dout0 = bus.r0_dout;
      prev_dout1 = bus.r1_dout;
    end
  end

  // at24c02_ctl model: random service delay, occasional stray valid while nothing is presented
  initial begin
    logic pend;
    logic nv;
    logic [7:0] nd;
    int dly;
    pend = 1'b0;
    dly = 0;
    bus.valid = 1'b0;
    bus.dout = 8'h00;
    forever begin
      @(negedge clk);
      nv = 1'b0;
      nd = 8'($urandom);
      if (rst || mute) begin
        pend = 1'b0;
      end else begin
        if (!pend && bus.ready) begin
          pend = 1'b1;
          cap_addr = bus.address;
          cap_din = bus.din;
          cap_wr = bus.wr_en;
          cap_last = bus.last;
          dly = $urandom_range(0, 3);
        end
        if (pend) begin
          if (dly == 0) begin
            nv = 1'b1;
            pend = 1'b0;
            valid_cyc = cyc;
            if (cap_wr) begin
              ee_mem[cap_addr] = cap_din;
              nd = cap_din;
            end else begin
              nd = ee_mem[cap_addr];
            end
          end else begin
            dly--;
          end
        end else if (!bus.ready && $urandom_range(0, 9) == 0) begin
          nv = 1'b1;
        end
      end
      #1;
      bus.valid = nv;
      bus.dout = nd;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 1'b0, 11'd0, 8'd0, 1'b0, 1'b0);
    set_req(1, 1'b0, 11'd0, 8'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_ctl", 32'({bus.ready, bus.address, bus.din, bus.wr_en, bus.last}), 32'd0);
    chk("reset_resp", 32'({bus.r0_ack, bus.r1_ack, bus.r0_err, bus.r1_err, bus.r0_dout, bus.r1_dout}), 32'd0);
    exp_q0.delete();
    exp_q1.delete();
    grant_log.delete();
    owner = -1;
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, rc, w;
    rst = 1'b1;
    mute = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      ref_mem[i] = pat(11'(i));
      ee_mem[i] = pat(11'(i));
    end
    set_req(0, 1'b0, 11'd0, 8'd0, 1'b0, 1'b0);
    set_req(1, 1'b0, 11'd0, 8'd0, 1'b0, 1'b0);
    do_reset();

    // Single write from r0: ready one cycle after req, then p moves to r1.
    fork
      do_burst(0, 1, 11'h123, 0, 8'h45, 1'b0);
      begin
        @(negedge clk);
        chk("pre_ready", 32'(bus.ready), 32'd0);
        @(negedge clk);
        chk("ready_lat", 32'(bus.ready), 32'd1);
        chk("w_fields", 32'({bus.address, bus.din, bus.wr_en, bus.last}), 32'({11'h123, 8'h45, 1'b1, 1'b1}));
      end
    join
    fork
      do_burst(0, 1, 11'h2a0, 2, -1, 1'b0);
      do_burst(1, 1, 11'h6a0, 2, -1, 1'b0);
    join
    chk_order("order_first", 3, 8'b010);

    // Simultaneous bursts after reset: r0 first, then alternation.
    do_reset();
    fork
      do_burst(0, 2, 11'h200, 2, -1, 1'b0);
      do_burst(1, 2, 11'h600, 2, -1, 1'b0);
    join
    fork
      do_burst(0, 2, 11'h210, 2, -1, 1'b0);
      do_burst(1, 2, 11'h610, 2, -1, 1'b0);
    join
    chk_order("order_simul", 4, 8'b1010);

    // r1 read burst keeps the grant while r0 waits.
    do_reset();
    fork
      do_burst(1, 3, 11'h010, 1, -1, 1'b0);
      begin
        repeat (2) @(negedge clk);
        do_burst(0, 1, 11'h300, 2, -1, 1'b0);
      end
    join
    chk_order("order_burst", 2, 8'b01);

    // Timeout with no valid: err after TO cycles of ISSUE, then r1 served.
    do_reset();
    mute = 1'b1;
    fork
      do_burst(0, 1, 11'h100, 1, -1, 1'b1);
      begin
        repeat (2) @(negedge clk);
        do_burst(1, 1, 11'h500, 1, -1, 1'b0);
      end
      begin
        w = 0;
        while (!bus.ready && w < 20) begin
          @(negedge clk);
          w++;
        end
        s = cyc;
        rc = 0;
        for (int k = 0; k < 30; k++) begin
          if (bus.r0_err) break;
          if (bus.ready) rc++;
          @(negedge clk);
        end
        chk("to_err_seen", 32'(bus.r0_err), 32'd1);
        chk("to_cycles", 32'(cyc - s), 32'(TO));
        chk("to_ready_cycles", 32'(rc), 32'(TO));
        chk("to_ready_drop", 32'(bus.ready), 32'd0);
        mute = 1'b0;
      end
    join
    chk_order("order_timeout", 2, 8'b10);

    // Reset during ISSUE: outputs clear at once, later request served normally.
    mute = 1'b1;
    @(negedge clk);
    #1 set_req(0, 1'b1, 11'h0ab, 8'h5a, 1'b1, 1'b1);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.ready && w < 10);
    chk("rst_pre_ready", 32'(bus.ready), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_ctl_zero", 32'({bus.ready, bus.address, bus.din, bus.wr_en, bus.last}), 32'd0);
    chk("rst_resp_zero", 32'({bus.r0_ack, bus.r1_ack, bus.r0_err, bus.r1_err, bus.r0_dout, bus.r1_dout}), 32'd0);
    set_req(0, 1'b0, 11'd0, 8'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    grant_log.delete();
    owner = -1;
    #1 rst = 1'b0;
    mute = 1'b0;
    do_burst(0, 1, 11'h0ab, 1, -1, 1'b0);
    chk_order("order_after_rst", 1, 8'b0);

    // Random contention between both requesters in disjoint address halves.
    for (int r = 0; r < 6; r++) begin
      fork
        repeat (4) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_burst(0, $urandom_range(1, 4), 11'($urandom_range(0, 1019)), 2, -1, 1'b0);
        end
        repeat (4) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_burst(1, $urandom_range(1, 4), 11'($urandom_range(1024, 2043)), 2, -1, 1'b0);
        end
      join
    end
    chk("queues_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eeprom_arb.md
EEPROM_ARB -- requirements
Module: eeprom_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 65535, the maximum cycles waited in ISSUE or HOLD before abort; legal range 1..2^20-1.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  the asynchronous, active-high reset.
REQ-004 SHALL have ports r0_req / r1_req  in  1  requester N asks for a byte transaction; held high until ack or err.
REQ-005 SHALL have ports r0_addr / r1_addr  in  11  requester EEPROM byte address.
REQ-006 SHALL have ports r0_din / r1_din  in  8  requester write data.
REQ-007 SHALL have ports r0_wr_en / r1_wr_en  in  1  1 = write, 0 = read.
REQ-008 SHALL have ports r0_last / r1_last  in  1  this beat ends the requester's burst and releases the grant.
REQ-009 SHALL have ports r0_ack / r1_ack  out  1  one-cycle pulse: beat complete.
REQ-010 SHALL have ports r0_err / r1_err  out  1  one-cycle pulse: beat aborted by timeout.
REQ-011 SHALL have ports r0_dout / r1_dout  out  8  read data, valid while the matching ack is high.
REQ-012 SHALL have ports address  out  11, din  out  8, wr_en  out  1, last  out  1  the fields driven to the at24c02_ctl instance.
REQ-013 SHALL have port ready  out  1  tells at24c02_ctl a transaction is presented.
REQ-014 SHALL have port valid  in  1  at24c02_ctl pulse: transaction done.
REQ-015 SHALL have port dout  in  8  at24c02_ctl read data, qualified by valid.

Function
REQ-016 SHALL implement states IDLE, ISSUE, DONE, HOLD.
REQ-017 IDLE: if any rN_req is high, SHALL register grant g and enter ISSUE next cycle; if both are high, SHALL grant the requester named by priority pointer p.
REQ-018 ISSUE: SHALL drive ready=1 and SHALL drive address, din, wr_en and last combinationally from requester g.
REQ-019 Outside ISSUE, SHALL drive ready=0 and address, din, wr_en and last to 0.
REQ-020 ISSUE, valid=1: SHALL capture dout into rg_dout and enter DONE next cycle, deasserting ready in that cycle.
REQ-021 DONE: SHALL pulse rg_ack for exactly one cycle.
REQ-022 DONE exit: if the captured last of the beat was 1, SHALL enter IDLE and set p to the other requester; otherwise SHALL enter HOLD.
REQ-023 HOLD: if rg_req=1, SHALL enter ISSUE next cycle; the requester presents its next beat the cycle after ack.
REQ-024 SHALL clear the timeout counter on entry to ISSUE and on entry to HOLD, and SHALL increment it each cycle spent in those states.
REQ-025 Timeout: when the counter reaches TIMEOUT in ISSUE or HOLD, SHALL pulse rg_err for one cycle, enter IDLE and set p to the other requester.
REQ-026 SHALL ignore valid in any state other than ISSUE.
REQ-027 SHALL ignore the ungranted requester's req until the grant is released; no preemption mid-burst.
REQ-028 SHALL keep rN_dout at its last captured value between acks.
REQ-029 Latency: req rising in IDLE at cycle t gives ready=1 at t+1; valid at cycle k gives ack at k+1.
REQ-030 The counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate without wrapping.

Reset
REQ-031 While rst=1, SHALL force state=IDLE, p=r0, g=r0, counter=0, ready=0, all acks and errs 0, all rN_dout and all ctl fields 0.
REQ-032 Reset asserted mid-transaction SHALL abort it silently, with no ack or err, and arbitration SHALL restart from IDLE after release.

Verification
REQ-033 Scenario: after reset, r0 writes addr 0x123, data 0x45, last=1 -> address=0x123, din=0x45, wr_en=1 and ready=1 one cycle after req; ack one cycle after valid; then IDLE with p=r1.
REQ-034 Scenario: r0 and r1 assert req in the same cycle -> r0 is granted first; r1 is granted after r0's last beat; a second simultaneous request then grants r0 only after r1 completes.
REQ-035 Scenario: r1 issues a 3-beat read burst at 0x010, 0x011, 0x012 while r0 requests -> r0 is not granted until r1's beat with last=1 acks; r1_dout matches the model bytes.
REQ-036 Scenario: TIMEOUT=8 and valid never returns -> err pulses 8 cycles after ISSUE entry, ready drops, and the other requester is served next.
REQ-037 Scenario: rst asserted while in ISSUE -> all outputs are 0 in the same cycle; a new request after release is served normally.
